// File: rtl/sprite_fetch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_fetch_arbiter
//  Purpose  : Shares the single sprite-ROM read port between the user
//             back-sprite row fetcher and the wild front-sprite row fetcher.
//             A granted request becomes a burst of sequential ROM reads.
//             Returned bytes are streamed out tagged with their owner.
//             The block also keeps the animation frame counter.
//  Ports    : Clk, Reset_n (async, active-low), frame_tick
//             u_req/u_addr/u_len/u_id -> u_ack   (user requester)
//             w_req/w_addr/w_len/w_id -> w_ack   (wild requester)
//             rom_addr, rom_sel, rom_phase -> ROM;  rom_data <- ROM (1-cycle)
//             out_valid, out_data, out_owner, out_last, busy
//  Config   : `define SPRITE_ANIM_EN builds the 5-bit frame counter.
//             rom_phase is then latched from counter[4] at each grant.
//             Without it, rom_phase is held at 0 (frame 1 only).
//  Revision : 1.0  initial release
// ============================================================================
module sprite_fetch_arbiter #(
    parameter int SPRITE_BYTES = 9216,
    parameter int ROW_MAX      = 96
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic        u_req,
    input  logic [13:0] u_addr,
    input  logic [6:0]  u_len,
    input  logic [4:0]  u_id,
    output logic        u_ack,
    input  logic        w_req,
    input  logic [13:0] w_addr,
    input  logic [6:0]  w_len,
    input  logic [4:0]  w_id,
    output logic        w_ack,
    output logic [13:0] rom_addr,
    output logic [4:0]  rom_sel,
    output logic        rom_phase,
    input  logic [7:0]  rom_data,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_owner,
    output logic        out_last,
    output logic        busy
);

    localparam logic [13:0] c_depth     = 14'(SPRITE_BYTES);
    localparam logic [13:0] c_last_addr = 14'(SPRITE_BYTES - 1);
    localparam logic [6:0]  c_row_max   = 7'(ROW_MAX);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t      r_state;
    logic [6:0]  r_remain;     // addresses still to issue after the current one
    logic        r_rr_wild;    // 1: wild wins the next tie
    logic        r_iss_valid;  // tag travelling with rom_addr
    logic        r_iss_owner;
    logic        r_iss_last;
    logic        r_p1_valid;   // tag aligned with rom_data
    logic        r_p1_owner;
    logic        r_p1_last;

    logic        w_cur_phase;
    logic        w_last_issue;
    logic        w_can_arb;
    logic        w_u_live;
    logic        w_w_live;
    logic        w_grant;
    logic        w_grant_wild;
    logic [13:0] w_sel_addr;
    logic [6:0]  w_sel_len;
    logic [4:0]  w_sel_id;
    logic [6:0]  w_len_eff;
    logic [13:0] w_start_addr;
    logic [13:0] w_next_addr;

    // ------------------------------------------------------------------
    // Animation phase source
    // ------------------------------------------------------------------
`ifdef SPRITE_ANIM_EN
    logic [4:0] r_frame_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_frame_cnt <= 5'd0;
        end else if (frame_tick) begin
            r_frame_cnt <= r_frame_cnt + 5'd1;
        end
    end

    // 16 video frames per animation frame
    assign w_cur_phase = r_frame_cnt[4];
`else
    logic w_unused_tick;
    assign w_unused_tick = frame_tick;
    assign w_cur_phase   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // The last issue cycle of a burst also arbitrates, so a waiting
    // requester gets its first address with no bubble.
    assign w_last_issue = (r_state == S_BURST) && (r_remain == 7'd0);
    assign w_can_arb    = (r_state == S_IDLE) || w_last_issue;

    // A requester still sees its req high during its own ack cycle; that
    // request has already been taken and must not be granted again.
    assign w_u_live     = u_req & ~u_ack;
    assign w_w_live     = w_req & ~w_ack;
    assign w_grant      = w_can_arb & (w_u_live | w_w_live);
    assign w_grant_wild = w_w_live & (~w_u_live | r_rr_wild);

    assign w_sel_addr = w_grant_wild ? w_addr : u_addr;
    assign w_sel_len  = w_grant_wild ? w_len  : u_len;
    assign w_sel_id   = w_grant_wild ? w_id   : u_id;

    assign w_len_eff = (w_sel_len == 7'd0)      ? 7'd1      :
                       (w_sel_len > c_row_max)  ? c_row_max : w_sel_len;

    // Fold an out-of-range start address back into the sprite so rom_addr
    // never leaves 0..SPRITE_BYTES-1.
    assign w_start_addr = (w_sel_addr >= c_depth) ? (w_sel_addr - c_depth) : w_sel_addr;
    assign w_next_addr  = (rom_addr == c_last_addr) ? 14'd0 : (rom_addr + 14'd1);

    assign busy = (r_state == S_BURST);

    // ------------------------------------------------------------------
    // Control FSM, address generator and return tag pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_remain    <= 7'd0;
            r_rr_wild   <= 1'b0;
            u_ack       <= 1'b0;
            w_ack       <= 1'b0;
            rom_addr    <= 14'd0;
            rom_sel     <= 5'd0;
            rom_phase   <= 1'b0;
            r_iss_valid <= 1'b0;
            r_iss_owner <= 1'b0;
            r_iss_last  <= 1'b0;
            r_p1_valid  <= 1'b0;
            r_p1_owner  <= 1'b0;
            r_p1_last   <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= 8'd0;
            out_owner   <= 1'b0;
            out_last    <= 1'b0;
        end else begin
            u_ack <= 1'b0;
            w_ack <= 1'b0;

            if (w_grant) begin
                u_ack       <= ~w_grant_wild;
                w_ack       <= w_grant_wild;
                rom_addr    <= w_start_addr;
                rom_sel     <= w_sel_id;
                rom_phase   <= w_cur_phase;
                r_remain    <= w_len_eff - 7'd1;
                r_rr_wild   <= ~w_grant_wild;
                r_state     <= S_BURST;
                r_iss_valid <= 1'b1;
                r_iss_owner <= w_grant_wild;
                r_iss_last  <= (w_len_eff == 7'd1);
            end else if ((r_state == S_BURST) && !w_last_issue) begin
                rom_addr    <= w_next_addr;
                r_remain    <= r_remain - 7'd1;
                r_iss_valid <= 1'b1;
                r_iss_last  <= (r_remain == 7'd1);
            end else begin
                r_state     <= S_IDLE;
                r_iss_valid <= 1'b0;
                r_iss_last  <= 1'b0;
            end

            // Tags follow the ROM's one-cycle latency, then register with data
            r_p1_valid <= r_iss_valid;
            r_p1_owner <= r_iss_owner;
            r_p1_last  <= r_iss_valid & r_iss_last;

            out_valid  <= r_p1_valid;
            out_owner  <= r_p1_owner;
            out_last   <= r_p1_valid & r_p1_last;
            out_data   <= rom_data;
        end
    end

endmodule
`default_nettype wire
